// File: rtl/poc_arbiter.sv
// Two-requester round-robin arbiter that owns one byte at a time and hands it to
// the parallel output controller over its SR/BR register bus (query or interrupt mode).
module poc_arbiter #(
    parameter int POLL_GAP = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic [1:0] grant,
    output logic       busy,
    input  logic       Switch,
    output logic       poc_sel,
    output logic       poc_rw,
    output logic       poc_addr,
    output logic [7:0] poc_dout,
    input  logic [7:0] poc_din,
    input  logic       poc_irq
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic       ADDR_SR = 1'b0;
    localparam logic       ADDR_BR = 1'b1;
    localparam logic [7:0] SR_CFG  = 8'h81;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GRANT,
        S_CFG,
        S_POLL_RD,
        S_POLL_CHK,
        S_POLL_WAIT,
        S_IRQ_WAIT,
        S_WR_BR,
        S_WR_SR,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         xfer_buf;
    logic               mode;
    logic               ie_set;
    logic               last_was1;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pick1;
    logic               unused_din;

    // Only the ready bit of SR drives any decision.
    assign unused_din = ^poc_din[6:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        pick1     = req1 & (~req0 | ~last_was1);
        case (state)
            S_IDLE:      if (req0 | req1) state_nxt = S_GRANT;
            S_GRANT: begin
                if (!mode)        state_nxt = S_POLL_RD;
                else if (!ie_set) state_nxt = S_CFG;
                else              state_nxt = S_IRQ_WAIT;
            end
            S_CFG:       state_nxt = S_IRQ_WAIT;
            S_POLL_RD:   state_nxt = S_POLL_CHK;
            S_POLL_CHK:  state_nxt = poc_din[7] ? S_WR_BR : S_POLL_WAIT;
            S_POLL_WAIT: if (gap_cnt == '0) state_nxt = S_POLL_RD;
            S_IRQ_WAIT:  if (poc_irq) state_nxt = S_WR_BR;
            S_WR_BR:     state_nxt = S_WR_SR;
            S_WR_SR:     state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each strobe lines up with its state's cycle.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            xfer_buf  <= '0;
            mode      <= 1'b0;
            ie_set    <= 1'b0;
            last_was1 <= 1'b1;
            gap_cnt   <= '0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            poc_sel   <= 1'b0;
            poc_rw    <= 1'b0;
            poc_addr  <= 1'b0;
            poc_dout  <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            poc_sel  <= 1'b0;
            poc_rw   <= 1'b0;
            poc_addr <= 1'b0;
            poc_dout <= '0;

            case (state)
                S_IDLE: begin
                    if (state_nxt == S_GRANT) begin
                        grant    <= pick1 ? 2'b10 : 2'b01;
                        xfer_buf <= pick1 ? data1 : data0;
                        mode     <= Switch;
                    end
                end
                S_CFG:       ie_set  <= 1'b1;
                S_POLL_CHK:  gap_cnt <= GAP_W'(POLL_GAP - 1);
                S_POLL_WAIT: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                // A query-mode SR write clears IE in the POC, so the next interrupt transfer reconfigures.
                S_WR_SR:     if (!mode) ie_set <= 1'b0;
                S_DONE: begin
                    grant     <= 2'b00;
                    last_was1 <= grant[1];
                end
                default: ;
            endcase

            case (state_nxt)
                S_CFG: begin
                    poc_sel  <= 1'b1;
                    poc_rw   <= 1'b1;
                    poc_addr <= ADDR_SR;
                    poc_dout <= SR_CFG;
                end
                S_POLL_RD: begin
                    poc_sel  <= 1'b1;
                    poc_addr <= ADDR_SR;
                end
                S_WR_BR: begin
                    poc_sel  <= 1'b1;
                    poc_rw   <= 1'b1;
                    poc_addr <= ADDR_BR;
                    poc_dout <= xfer_buf;
                end
                S_WR_SR: begin
                    poc_sel  <= 1'b1;
                    poc_rw   <= 1'b1;
                    poc_addr <= ADDR_SR;
                    poc_dout <= {7'd0, mode};
                end
                S_DONE: begin
                    ack0 <= grant[0];
                    ack1 <= grant[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poc_arbiter.sv
// Bench for poc_arbiter: a transaction-level model predicts every output cycle,
// directed scenarios pin exact bus sequences and ack timing, then random traffic runs.
module tb_poc_arbiter;

    localparam int POLL_GAP = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic [7:0] data1 = 8'h00;
    logic       Switch = 1'b0;
    logic [7:0] poc_din = 8'h00;
    logic       poc_irq = 1'b0;
    logic       ack0;
    logic       ack1;
    logic [1:0] grant;
    logic       busy;
    logic       poc_sel;
    logic       poc_rw;
    logic       poc_addr;
    logic [7:0] poc_dout;

    poc_arbiter #(.POLL_GAP(POLL_GAP)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .ack0     (ack0),
        .ack1     (ack1),
        .grant    (grant),
        .busy     (busy),
        .Switch   (Switch),
        .poc_sel  (poc_sel),
        .poc_rw   (poc_rw),
        .poc_addr (poc_addr),
        .poc_dout (poc_dout),
        .poc_din  (poc_din),
        .poc_irq  (poc_irq)
    );

    always #5 CLK = ~CLK;

    typedef struct { int cyc; logic rw; logic addr; logic [7:0] d; } bus_t;
    typedef struct { int cyc; int who; } ack_t;

    bus_t       bus_q[$];
    ack_t       ack_q[$];
    int         cyc_n = 0;
    int         rd_cnt = 0;
    int         rd_base = 0;
    int         ready_after = 0;
    int         resp_mode = 0;
    logic [7:0] resp_val = 8'h00;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    always @(posedge CLK) cyc_n <= cyc_n + 1;

    // Bus and ack monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (poc_sel) begin
            bus_q.push_back('{cyc_n, poc_rw, poc_addr, poc_dout});
            if (!poc_rw) rd_cnt <= rd_cnt + 1;
        end
        if (ack0) ack_q.push_back('{cyc_n, 0});
        if (ack1) ack_q.push_back('{cyc_n, 1});
    end

    // POC status responder: fixed value, ready after N reads, or random.
    initial forever begin
        @(posedge CLK);
        #1;
        case (resp_mode)
            0:       poc_din = resp_val;
            1:       poc_din = ((rd_cnt - rd_base) >= ready_after) ? 8'h80 : 8'h00;
            default: poc_din = {1'($urandom_range(0, 1)), 7'($urandom)};
        endcase
    end

    // ---------------- behavioural model ----------------
    logic m_ie    = 1'b0;
    logic m_last  = 1'b1;
    logic m_abort = 1'b0;

    function automatic logic [15:0] m_out(input logic [1:0] g, input logic a, input logic sel,
                                          input logic rw, input logic addr, input logic [7:0] d);
        return {g, (g != 2'b00), a & g[0], a & g[1], sel, rw, addr, d};
    endfunction

    task automatic m_cyc(input logic [15:0] exp);
        @(negedge CLK);
        check("outputs", 32'({grant, busy, ack0, ack1, poc_sel, poc_rw, poc_addr, poc_dout}), 32'(exp));
        if (RST) m_abort = 1'b1;
    endtask

    task automatic m_xfer();
        logic       own;
        logic [1:0] g;
        logic [7:0] b;
        logic       md;
        own = (req0 && req1) ? ~m_last : req1;
        g   = own ? 2'b10 : 2'b01;
        b   = own ? data1 : data0;
        md  = Switch;
        m_cyc(m_out(g, 0, 0, 0, 0, 8'h00)); if (m_abort) return;
        if (!md) begin
            forever begin
                m_cyc(m_out(g, 0, 1, 0, 0, 8'h00)); if (m_abort) return;
                m_cyc(m_out(g, 0, 0, 0, 0, 8'h00)); if (m_abort) return;
                if (poc_din[7]) break;
                for (int i = 0; i < POLL_GAP; i++) begin
                    m_cyc(m_out(g, 0, 0, 0, 0, 8'h00)); if (m_abort) return;
                end
            end
        end else begin
            if (!m_ie) begin
                m_cyc(m_out(g, 0, 1, 1, 0, 8'h81)); if (m_abort) return;
                m_ie = 1'b1;
            end
            forever begin
                m_cyc(m_out(g, 0, 0, 0, 0, 8'h00)); if (m_abort) return;
                if (poc_irq) break;
            end
        end
        m_cyc(m_out(g, 0, 1, 1, 1, b)); if (m_abort) return;
        m_cyc(m_out(g, 0, 1, 1, 0, {7'd0, md})); if (m_abort) return;
        if (!md) m_ie = 1'b0;
        m_cyc(m_out(g, 1, 0, 0, 0, 8'h00)); if (m_abort) return;
        m_last = own;
    endtask

    initial begin
        @(posedge CLK);
        forever begin
            if (m_abort) begin
                m_abort = 1'b0;
                m_ie    = 1'b0;
                m_last  = 1'b1;
            end
            m_cyc(16'h0000);
            if (!m_abort && (req0 || req1)) m_xfer();
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (ack_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("ack_count", 32'(ack_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_reached", 32'(busy), 32'(0));
        tick();
    endtask

    function automatic logic [31:0] bus_word(input int idx, input int t);
        if (idx >= bus_q.size()) return 32'hFFFF_FFFF;
        return {22'(bus_q[idx].cyc - t), bus_q[idx].rw, bus_q[idx].addr, bus_q[idx].d};
    endfunction

    function automatic logic [31:0] bw(input int off, input logic rw, input logic addr, input logic [7:0] d);
        return {22'(off), rw, addr, d};
    endfunction

    function automatic logic [31:0] ack_word(input int idx, input int t);
        if (idx >= ack_q.size()) return 32'hFFFF_FFFF;
        return {24'(ack_q[idx].cyc - t), 8'(ack_q[idx].who)};
    endfunction

    function automatic logic [31:0] aw(input int off, input int who);
        return {24'(off), 8'(who)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int b0;
        int a0;
        int t;

        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check("reset_outputs", 32'({grant, busy, ack0, ack1, poc_sel, poc_rw, poc_addr, poc_dout}), 32'h0);

        // Query mode, ready immediately.
        resp_mode = 0; resp_val = 8'h80; Switch = 1'b0;
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req0 = 1'b1; data0 = 8'hF0; t = cyc_n;
        tick(); req0 = 1'b0;
        wait_acks(a0 + 1, 40);
        check("q_nbus", 32'(bus_q.size() - b0), 32'd3);
        check("q_read_sr", bus_word(b0, t),     bw(2, 0, 0, 8'h00));
        check("q_write_br", bus_word(b0 + 1, t), bw(4, 1, 1, 8'hF0));
        check("q_write_sr", bus_word(b0 + 2, t), bw(5, 1, 0, 8'h00));
        check("q_ack", ack_word(a0, t), aw(6, 0));
        wait_idle(40);

        // Query mode, three not-ready reads before ready.
        resp_mode = 1; ready_after = 4; rd_base = rd_cnt;
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req0 = 1'b1; data0 = 8'h0F; t = cyc_n;
        tick(); req0 = 1'b0;
        wait_acks(a0 + 1, 80);
        check("poll_nreads", 32'(rd_cnt - rd_base), 32'd4);
        for (int i = 0; i < 4; i++)
            check("poll_read", bus_word(b0 + i, t), bw(2 + 6 * i, 0, 0, 8'h00));
        check("poll_br", bus_word(b0 + 4, t), bw(22, 1, 1, 8'h0F));
        check("poll_sr", bus_word(b0 + 5, t), bw(23, 1, 0, 8'h00));
        check("poll_ack", ack_word(a0, t), aw(24, 0));
        wait_idle(40);
        check("poll_ack_once", 32'(ack_q.size() - a0), 32'd1);

        // Interrupt mode after reset: CFG first, BR only after irq.
        RST = 1'b1; tick(); tick(); RST = 1'b0;
        resp_mode = 0; resp_val = 8'h00; Switch = 1'b1; poc_irq = 1'b0;
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req1 = 1'b1; data1 = 8'h6F; t = cyc_n;
        tick(); req1 = 1'b0;
        while (cyc_n < t + 10) tick();
        poc_irq = 1'b1;
        wait_acks(a0 + 1, 40);
        check("irq_cfg", bus_word(b0, t),     bw(2, 1, 0, 8'h81));
        check("irq_br", bus_word(b0 + 1, t),  bw(11, 1, 1, 8'h6F));
        check("irq_sr", bus_word(b0 + 2, t),  bw(12, 1, 0, 8'h01));
        check("irq_ack", ack_word(a0, t), aw(13, 1));
        wait_idle(40);

        // Both requesters held: strict alternation starting with requester 0.
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req0 = 1'b1; req1 = 1'b1; data0 = 8'hAA; data1 = 8'h55; t = cyc_n;
        wait_acks(a0 + 4, 60);
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rr_ack", ack_word(a0 + k, t), aw(5 + 6 * k, k % 2));
            check("rr_br", bus_word(b0 + 2 * k, t), bw(3 + 6 * k, 1, 1, (k % 2 == 0) ? 8'hAA : 8'h55));
        end
        wait_idle(40);

        // One-cycle request pulse still completes.
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req0 = 1'b1; data0 = 8'h3C; t = cyc_n;
        tick(); req0 = 1'b0; data0 = 8'h00;
        wait_acks(a0 + 1, 40);
        check("pulse_br", bus_word(b0, t), bw(3, 1, 1, 8'h3C));
        check("pulse_sr", bus_word(b0 + 1, t), bw(4, 1, 0, 8'h01));
        check("pulse_ack", ack_word(a0, t), aw(5, 0));
        wait_idle(40);

        // Reset while waiting for irq aborts the transfer; CFG comes back afterwards.
        poc_irq = 1'b0;
        b0 = bus_q.size(); a0 = ack_q.size();
        tick(); req0 = 1'b1; data0 = 8'h5A; t = cyc_n;
        tick(); req0 = 1'b0;
        tick();
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        @(negedge CLK);
        check("abort_state", 32'({grant, busy}), 32'h0);
        repeat (10) tick();
        check("abort_no_ack", 32'(ack_q.size() - a0), 32'd0);
        check("abort_no_bus", 32'(bus_q.size() - b0), 32'd0);
        poc_irq = 1'b1;
        tick(); req1 = 1'b1; data1 = 8'hC3; t = cyc_n;
        tick(); req1 = 1'b0;
        wait_acks(a0 + 1, 40);
        check("recfg_cfg", bus_word(b0, t), bw(2, 1, 0, 8'h81));
        check("recfg_br", bus_word(b0 + 1, t), bw(4, 1, 1, 8'hC3));
        check("recfg_ack", ack_word(a0, t), aw(6, 1));
        wait_idle(40);

        // Random traffic against the model.
        resp_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!busy && $urandom_range(0, 15) == 0) begin
                Switch = ~Switch;
                req0 = 1'b0;
                req1 = 1'b0;
            end else begin
                if (!req0) begin
                    if ($urandom_range(0, 3) == 0) begin req0 = 1'b1; data0 = 8'($urandom); end
                end else if ($urandom_range(0, 2) == 0) req0 = 1'b0;
                if (!req1) begin
                    if ($urandom_range(0, 3) == 0) begin req1 = 1'b1; data1 = 8'($urandom); end
                end else if ($urandom_range(0, 2) == 0) req1 = 1'b0;
            end
            poc_irq = ($urandom_range(0, 2) == 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(300);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poc_arbiter.md
# poc_arbiter

Two-requester arbiter and transfer sequencer for the parallel output controller (POC). It grants one requester at a time with round-robin fairness and latches that requester's byte. It then drives the POC register bus to hand the byte to the printer, in either query (polling) or interrupt mode as selected by `Switch`. It sits between the processor-side byte sources and the POC inside `top`.

## Interface
- `POLL_GAP`, 4: idle cycles between consecutive SR reads in query mode (≥1).
- `CLK` input 1: system clock, all logic on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1: transfer requests.
- `data0`, `data1` input 8: byte to print, valid while the matching req is high.
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `grant` output 2: one-hot current owner, 2'b00 when idle.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `Switch` input 1: 0 = query mode, 1 = interrupt mode; sampled at grant.
- `poc_sel` output 1: POC bus cycle strobe.
- `poc_rw` output 1: 1 = write, 0 = read.
- `poc_addr` output 1: 0 = SR (status), 1 = BR (buffer).
- `poc_dout` output 8: write data to POC.
- `poc_din` input 8: SR read data; bit7 = ready, bit0 = IE.
- `poc_irq` input 1: POC interrupt, high while SR[7] & SR[0].

## Operation
- POC contract:
  - Writing SR with bit7=0 starts printing BR and clears ready.
  - Writing SR with bit7=1 only updates IE.
- States: IDLE, GRANT, CFG, POLL_RD, POLL_CHK, POLL_WAIT, IRQ_WAIT, WR_BR, WR_SR, DONE.
- IDLE: if any req is high, go to GRANT. Both high: grant the requester not served last. After reset, requester 0 has priority.
- GRANT:
  - Set grant one-hot, latch the byte into `buf`, latch `Switch` into `mode`.
  - mode=0: go to POLL_RD.
  - mode=1 and `ie_set`=0: go to CFG.
  - mode=1 and `ie_set`=1: go to IRQ_WAIT.
- CFG: one write cycle, SR = 8'h81. Set `ie_set`, then go to IRQ_WAIT.
- POLL_RD: one read cycle of SR, then go to POLL_CHK.
- POLL_CHK: sample `poc_din`.
  - bit7=1: go to WR_BR.
  - Otherwise: go to POLL_WAIT, count POLL_GAP cycles, then return to POLL_RD.
- IRQ_WAIT: no bus activity. When `poc_irq`=1, go to WR_BR.
- WR_BR: one write cycle, BR = `buf`.
- WR_SR: one write cycle.
  - SR = 8'h00 in query mode (IE clears, so `ie_set` clears).
  - SR = 8'h01 in interrupt mode (IE kept).
- DONE:
  - Pulse ack for the owner and update the round-robin pointer.
  - Clear grant, return to IDLE.
- Data is latched at GRANT. If req drops early, the transfer still completes and ack is still pulsed.
- A `Switch` change during a transfer takes effect at the next GRANT. A 0→1 change finds `ie_set`=0, so CFG is re-issued.
- No timeout: an absent ready bit or irq holds the FSM indefinitely.

## Timing
- Reset values:
  - All outputs 0.
  - `buf`=0, `ie_set`=0, pointer favours requester 0, state IDLE.
- `poc_sel` is high exactly one cycle per bus access, with `poc_rw`, `poc_addr` and `poc_dout` valid in that same cycle. Outside accesses, all four are 0.
- Read data is sampled in the cycle after the read strobe (POLL_CHK).
- Query-mode best case (counted from cycle T, when req is first seen high in IDLE):
  - T+1 GRANT, T+2 POLL_RD, T+3 POLL_CHK, T+4 WR_BR, T+5 WR_SR, T+6 DONE (ack high).
  - Each not-ready check adds POLL_GAP+2 cycles.
- Interrupt mode, `ie_set`=1 and irq already high: ack at T+5. The first transfer after reset adds one cycle for CFG.
- Back-to-back: req still high in the cycle after DONE starts a new arbitration. Minimum spacing between acks is 6 cycles.
- A reset asserted mid-transfer aborts immediately; no ack is issued and the next cycle shows reset values.

## Test plan
- Query mode, SR=8'h80, req0 with 8'hF0 → bus sequence: read SR, write BR=8'hF0, write SR=8'h00; ack0 at T+6.
- Query mode, SR=8'h00 for 3 reads then 8'h80, POLL_GAP=4, 8'h0F → exactly 4 SR reads spaced 6 cycles apart, then BR=8'h0F; ack0 once.
- Interrupt mode after reset, req1 with 8'h6F, irq raised 10 cycles later → CFG write SR=8'h81 first, no BR write before irq, then BR=8'h6F and SR=8'h01; ack1.
- req0 and req1 held high together, data 8'hAA / 8'h55 → grant order 0,1,0,1; BR writes alternate AA,55; no starvation.
- req0 pulsed for one cycle with 8'h3C → transfer completes, BR=8'h3C, ack0 pulsed.
- RST asserted in IRQ_WAIT → next cycle busy=0, grant=0, no ack; next interrupt-mode transfer re-issues CFG.
